// File: rtl/bomb_fuse_square.sv
// Bomb position and fuse sequencer for the bomb bitmap stage.
// Latches a tile-aligned bomb position on a rising place request, runs the
// ARMED -> BLINK -> EXPLODE fuse on frame pulses, and tells the bitmap which
// scanned pixels fall inside the visible 32x32 bomb square and where.
module bomb_fuse_square #(
   parameter int OBJECT_WIDTH   = 32,
   parameter int OBJECT_HEIGHT  = 32,
   parameter int FUSE_FRAMES    = 120,
   parameter int BLINK_FRAMES   = 40,
   parameter int BLINK_PERIOD   = 8,
   parameter int EXPLODE_FRAMES = 30
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic [10:0] playerX,
   input  logic [10:0] playerY,
   input  logic        placeRequest,
   output logic        InsideRectangle,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic        bombActive,
   output logic        exploding,
   output logic        explodePulse,
   output logic [10:0] bombX,
   output logic [10:0] bombY
);

   // Counter must hold the longest phase length minus one.
   localparam int MAX_AB      = (FUSE_FRAMES > BLINK_FRAMES) ? FUSE_FRAMES : BLINK_FRAMES;
   localparam int MAX_FRAMES  = (MAX_AB > EXPLODE_FRAMES) ? MAX_AB : EXPLODE_FRAMES;
   localparam int CNT_W       = $clog2(MAX_FRAMES + 1);
   // Bit of the frame counter that toggles once per blink half-period.
   localparam int BLINK_SHIFT = $clog2(BLINK_PERIOD);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_BLINK   = 2'd2,
      ST_EXPLODE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [10:0]       bomb_x_q, bomb_x_d;
   logic [10:0]       bomb_y_q, bomb_y_d;
   logic              prev_place_q;
   logic              explode_pulse_q, explode_pulse_d;

   logic              place_edge;
   logic              visible;
   logic              inside_x, inside_y;
   logic [11:0]       px_ext, py_ext, bx_ext, by_ext;

   assign place_edge = placeRequest & ~prev_place_q;

   // Next-state logic: placement in IDLE, frame counting and phase changes elsewhere.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
      state_d         = state_q;
      frame_cnt_d     = frame_cnt_q;
      bomb_x_d        = bomb_x_q;
      bomb_y_d        = bomb_y_q;
      explode_pulse_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Placement wins over a coincident frame pulse: counter starts at 0.
            if (place_edge) begin
               state_d     = ST_ARMED;
               frame_cnt_d = '0;
               bomb_x_d    = (playerX + 11'(OBJECT_WIDTH / 2))  & ~11'(OBJECT_WIDTH - 1);
               bomb_y_d    = (playerY + 11'(OBJECT_HEIGHT / 2)) & ~11'(OBJECT_HEIGHT - 1);
            end
         end
         ST_ARMED: begin
            if (startOfFrame) begin
               if (frame_cnt_q == CNT_W'(FUSE_FRAMES - 1)) begin
                  state_d     = ST_BLINK;
                  frame_cnt_d = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_BLINK: begin
            if (startOfFrame) begin
               if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                  state_d         = ST_EXPLODE;
                  frame_cnt_d     = '0;
                  explode_pulse_d = 1'b1;
               end else begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_EXPLODE: begin
            if (startOfFrame) begin
               if (frame_cnt_q == CNT_W'(EXPLODE_FRAMES - 1)) begin
                  state_d     = ST_IDLE;
                  frame_cnt_d = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            frame_cnt_d = '0;
         end
      endcase
   end

   // State registers; reset drops straight back to IDLE with no pulse.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q         <= ST_IDLE;
         frame_cnt_q     <= '0;
         bomb_x_q        <= '0;
         bomb_y_q        <= '0;
         prev_place_q    <= 1'b0;
         explode_pulse_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
         state_q         <= state_d;
         frame_cnt_q     <= frame_cnt_d;
         bomb_x_q        <= bomb_x_d;
         bomb_y_q        <= bomb_y_d;
         prev_place_q    <= placeRequest;
         explode_pulse_q <= explode_pulse_d;
      end
   end

   // Visibility: solid while armed, square-wave blink during BLINK, hidden otherwise.
   always_comb begin
      visible = 1'b0;
      unique case (state_q)
         ST_ARMED: visible = 1'b1;
         ST_BLINK: visible = ~frame_cnt_q[BLINK_SHIFT];
         default:  visible = 1'b0;
      endcase
   end

   // Rectangle test widened to 12 bits so a bomb at the right/bottom edge
   // does not wrap its far boundary to zero.
   always_comb begin
      px_ext          = {1'b0, pixelX};
      py_ext          = {1'b0, pixelY};
      bx_ext          = {1'b0, bomb_x_q};
      by_ext          = {1'b0, bomb_y_q};
      inside_x        = (px_ext >= bx_ext) && (px_ext < bx_ext + 12'(OBJECT_WIDTH));
      inside_y        = (py_ext >= by_ext) && (py_ext < by_ext + 12'(OBJECT_HEIGHT));
      InsideRectangle = visible & inside_x & inside_y;
      offsetX         = InsideRectangle ? (pixelX - bomb_x_q) : 11'd0;
      offsetY         = InsideRectangle ? (pixelY - bomb_y_q) : 11'd0;
   end

   assign bombActive   = (state_q != ST_IDLE);
   assign exploding    = (state_q == ST_EXPLODE);
   assign explodePulse = explode_pulse_q;
   assign bombX        = bomb_x_q;
   assign bombY        = bomb_y_q;

endmodule

// File: tb/tb_bomb_fuse_square.sv
// Self-checking bench for bomb_fuse_square: directed fuse walk-through,
// reset mid-blink, then randomized traffic against a frame-count model.
module tb_bomb_fuse_square;

   localparam int W     = 32;
   localparam int H     = 32;
   localparam int FUSE  = 120;
   localparam int BLINK = 40;
   localparam int BPER  = 8;
   localparam int EXPL  = 30;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        placeRequest = 1'b0;
   logic [10:0] pixelX = '0;
   logic [10:0] pixelY = '0;
   logic [10:0] playerX = '0;
   logic [10:0] playerY = '0;
   logic        InsideRectangle;
   logic [10:0] offsetX, offsetY;
   logic        bombActive, exploding, explodePulse;
   logic [10:0] bombX, bombY;

   int n_checks = 0;
   int n_errors = 0;
   int sof_cnt = 0;
   int pulse_cnt = 0;
   int pulse_at = -1;

   always #5 clk = ~clk;

   bomb_fuse_square #(
      .OBJECT_WIDTH(W), .OBJECT_HEIGHT(H), .FUSE_FRAMES(FUSE),
      .BLINK_FRAMES(BLINK), .BLINK_PERIOD(BPER), .EXPLODE_FRAMES(EXPL)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .pixelX(pixelX), .pixelY(pixelY), .playerX(playerX), .playerY(playerY),
      .placeRequest(placeRequest), .InsideRectangle(InsideRectangle),
      .offsetX(offsetX), .offsetY(offsetY), .bombActive(bombActive),
      .exploding(exploding), .explodePulse(explodePulse),
      .bombX(bombX), .bombY(bombY)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: one count of frames since placement; the phase is
   // derived from that count rather than tracked as a state.
   logic m_active, m_prev, m_pulse;
   int   m_frames, m_bx, m_by;

   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         m_active <= 1'b0;
         m_prev   <= 1'b0;
         m_pulse  <= 1'b0;
         m_frames <= 0;
         m_bx     <= 0;
         m_by     <= 0;
      end else begin
         m_prev  <= placeRequest;
         m_pulse <= 1'b0;
         if (!m_active) begin
            if (placeRequest && !m_prev) begin
               m_active <= 1'b1;
               m_frames <= 0;
               m_bx     <= ((int'(playerX) + W / 2) % 2048) / W * W;
               m_by     <= ((int'(playerY) + H / 2) % 2048) / H * H;
            end
         end else if (startOfFrame) begin
            if (m_frames == FUSE + BLINK + EXPL - 1) begin
               m_active <= 1'b0;
               m_frames <= 0;
            end else begin
               m_frames <= m_frames + 1;
            end
            if (m_frames == FUSE + BLINK - 1) m_pulse <= 1'b1;
         end
      end
   end

   // Compare every cycle on the falling edge, away from the active edge.
   always @(negedge clk) begin : cmp_proc
      int   px, py, ex_offx, ex_offy;
      logic ex_armed, ex_blink, ex_expl, ex_vis, ex_in;
      px       = int'(pixelX);
      py       = int'(pixelY);
      ex_armed = m_active && (m_frames < FUSE);
      ex_blink = m_active && (m_frames >= FUSE) && (m_frames < FUSE + BLINK);
      ex_expl  = m_active && (m_frames >= FUSE + BLINK);
      ex_vis   = ex_armed || (ex_blink && (((m_frames - FUSE) / BPER) % 2 == 0));
      ex_in    = ex_vis && (px >= m_bx) && (px < m_bx + W) && (py >= m_by) && (py < m_by + H);
      ex_offx  = ex_in ? px - m_bx : 0;
      ex_offy  = ex_in ? py - m_by : 0;
      check("cmp_inside",   32'(InsideRectangle), 32'(ex_in));
      check("cmp_offx",     32'(offsetX),         ex_offx);
      check("cmp_offy",     32'(offsetY),         ex_offy);
      check("cmp_active",   32'(bombActive),      32'(m_active));
      check("cmp_explode",  32'(exploding),       32'(ex_expl));
      check("cmp_pulse",    32'(explodePulse),    32'(m_pulse));
      check("cmp_bombx",    32'(bombX),           m_bx);
      check("cmp_bomby",    32'(bombY),           m_by);
      if (explodePulse === 1'b1) begin
         pulse_cnt++;
         pulse_at = sof_cnt;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_pixel();
      if ($urandom_range(0, 3) == 0) begin
         pixelX = 11'($urandom);
         pixelY = 11'($urandom);
      end else begin
         pixelX = 11'(m_bx + int'($urandom_range(0, 47)) - 8);
         pixelY = 11'(m_by + int'($urandom_range(0, 47)) - 8);
      end
   endtask

   task automatic do_frame(input int idle_cycles);
      startOfFrame = 1'b1;
      rand_pixel();
      tick();
      startOfFrame = 1'b0;
      sof_cnt++;
      repeat (idle_cycles) begin
         rand_pixel();
         tick();
      end
   endtask

   task automatic probe(input int x, input int y, input logic ex_in, input int ex_ox, input int ex_oy);
      tick();
      pixelX = 11'(x);
      pixelY = 11'(y);
      #1;
      check("probe_inside", 32'(InsideRectangle), 32'(ex_in));
      check("probe_offx",   32'(offsetX),         ex_ox);
      check("probe_offy",   32'(offsetY),         ex_oy);
   endtask

   initial begin
      int   k;
      logic ex_in;

      // Reset state.
      resetN = 1'b0;
      repeat (3) tick();
      check("rst_active",  32'(bombActive),      0);
      check("rst_explode", 32'(exploding),       0);
      check("rst_pulse",   32'(explodePulse),    0);
      check("rst_bombx",   32'(bombX),           0);
      check("rst_bomby",   32'(bombY),           0);
      check("rst_inside",  32'(InsideRectangle), 0);
      resetN = 1'b1;
      tick();

      // Placement with player at (100,70).
      playerX      = 11'd100;
      playerY      = 11'd70;
      placeRequest = 1'b1;
      tick();
      check("place_bombx",  32'(bombX),      96);
      check("place_bomby",  32'(bombY),      64);
      check("place_active", 32'(bombActive), 1);
      check("model_bx",     m_bx,            96);
      check("model_by",     m_by,            64);

      // Pixel sweep around the bomb at (96,64).
      probe(96, 64, 1'b1, 0, 0);
      probe(127, 95, 1'b1, 31, 31);
      probe(128, 64, 1'b0, 0, 0);
      probe(95, 64, 1'b0, 0, 0);
      probe(100, 96, 1'b0, 0, 0);
      probe(110, 63, 1'b0, 0, 0);

      // Full fuse with placeRequest held, plus a second edge while armed.
      sof_cnt   = 0;
      pulse_cnt = 0;
      for (int f = 1; f <= FUSE + BLINK + EXPL; f++) begin
         do_frame(2);
         if (f == 50) begin
            placeRequest = 1'b0;
            tick();
            playerX      = 11'd500;
            placeRequest = 1'b1;
            tick();
            check("reedge_bombx", 32'(bombX), 96);
            check("reedge_bomby", 32'(bombY), 64);
         end
         pixelX = 11'd101;
         pixelY = 11'd69;
         #1;
         k = f - 120;
         if (f < 120)       ex_in = 1'b1;
         else if (f < 160)  ex_in = !((k >= 8 && k <= 15) || (k >= 24 && k <= 31));
         else               ex_in = 1'b0;
         check("fuse_inside",  32'(InsideRectangle), 32'(ex_in));
         check("fuse_explode", 32'(exploding),       32'(f >= 160 && f < 190));
         check("fuse_active",  32'(bombActive),      32'(f < 190));
      end
      check("pulse_count", pulse_cnt, 1);
      check("pulse_frame", pulse_at, 160);

      // Request still held across the return to IDLE: no re-placement.
      repeat (5) tick();
      check("held_no_place", 32'(bombActive), 0);
      check("held_bombx",    32'(bombX),      96);
      placeRequest = 1'b0;
      tick();
      placeRequest = 1'b1;
      tick();
      check("new_edge_active", 32'(bombActive), 1);
      check("new_edge_bombx",  32'(bombX),      512);
      check("new_edge_bomby",  32'(bombY),      64);

      // Async reset at BLINK frame 10.
      sof_cnt   = 0;
      pulse_cnt = 0;
      repeat (FUSE + 10) do_frame(2);
      pixelX = 11'd517;
      pixelY = 11'd69;
      #1;
      check("blink10_active", 32'(bombActive),      1);
      check("blink10_hidden", 32'(InsideRectangle), 0);
      pixelX = 11'd517;
      pixelY = 11'd69;
      #1;
      resetN = 1'b0;
      #1;
      check("async_active",  32'(bombActive),      0);
      check("async_explode", 32'(exploding),       0);
      check("async_pulse",   32'(explodePulse),    0);
      check("async_bombx",   32'(bombX),           0);
      check("async_bomby",   32'(bombY),           0);
      check("async_inside",  32'(InsideRectangle), 0);
      check("async_offx",    32'(offsetX),         0);
      check("async_offy",    32'(offsetY),         0);
      placeRequest = 1'b0;
      repeat (40) do_frame(2);
      check("async_no_pulse", pulse_cnt, 0);
      resetN = 1'b1;
      tick();

      // Placement with 11-bit wrap of the rounding add.
      playerX      = 11'd2040;
      playerY      = 11'd2030;
      placeRequest = 1'b1;
      tick();
      check("wrap_bombx", 32'(bombX), 0);
      check("wrap_bomby", 32'(bombY), 2016);
      probe(31, 2047, 1'b1, 31, 31);
      probe(0, 2015, 1'b0, 0, 0);

      // Randomized traffic, including frame pulses coincident with edges.
      for (int i = 0; i < 5000; i++) begin
         startOfFrame = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) placeRequest = ~placeRequest;
         if ($urandom_range(0, 49) == 0) begin
            playerX = 11'($urandom);
            playerY = 11'($urandom);
         end
         rand_pixel();
         tick();
      end
      startOfFrame = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
